// File: rtl/microseq_pkg.sv
// Shared encodings and microword field layout for the microprogram sequencer.
package microseq_pkg;

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_BRC      = 3'd2,
    OP_DISPATCH = 3'd3,
    OP_CALL     = 3'd4,
    OP_RET      = 3'd5,
    OP_WAIT     = 3'd6,
    OP_END      = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    COND_TRUE = 3'd0,
    COND_Z    = 3'd1,
    COND_N    = 3'd2,
    COND_C    = 3'd3,
    COND_V    = 3'd4,
    COND_NZ   = 3'd5,
    COND_NN   = 3'd6,
    COND_NC   = 3'd7
  } cond_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Microword layout, LSB first: ctrl | op(3) | cond(3) | target(ADDR_W)
  function automatic int op_lsb(input int ctrl_w);
    return ctrl_w;
  endfunction

  function automatic int cond_lsb(input int ctrl_w);
    return ctrl_w + 3;
  endfunction

  function automatic int target_lsb(input int ctrl_w);
    return ctrl_w + 6;
  endfunction

  function automatic int uword_width(input int ctrl_w, input int addr_w);
    return ctrl_w + 6 + addr_w;
  endfunction

endpackage

// File: rtl/micro_stack.sv
// Return-address LIFO for microsubroutine calls; push and pop share the CAR update edge.
module micro_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int ADDR_W      = 7
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [SP_W-1:0]   sp_reg;
  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]  top_idx;

  assign full    = (sp_reg == SP_W'(STACK_DEPTH));
  assign empty   = (sp_reg == '0);
  assign top_idx = PTR_W'(sp_reg - SP_W'(1));
  // Top of stack is read combinationally so RET can redirect in the same cycle
  assign dout    = mem[top_idx];

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + SP_W'(1);
    end else if (pop && !empty) begin
      sp_reg <= sp_reg - SP_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !full) begin
      mem[PTR_W'(sp_reg)] <= din;
    end
  end

endmodule

// File: rtl/microsequencer_stack.sv
// Microprogram sequencer: CAR, next-address/cond muxes, return stack, WAIT stall and fault halt.
module microsequencer_stack
  import microseq_pkg::*;
#(
  parameter int              ADDR_W      = 7,
  parameter int              CTRL_W      = 27,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       CLK,
  input  logic                       reset_n,
  output logic [ADDR_W-1:0]          uaddr,
  input  logic [CTRL_W+6+ADDR_W-1:0] uword,
  input  logic [ADDR_W-1:0]          map_addr,
  input  logic [3:0]                 flags,
  input  logic                       mem_done,
  input  logic                       hold,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic                       done,
  output logic                       err
);

  localparam int OP_LSB   = op_lsb(CTRL_W);
  localparam int COND_LSB = cond_lsb(CTRL_W);
  localparam int TGT_LSB  = target_lsb(CTRL_W);

  op_e               op;
  cond_e             cond;
  logic [ADDR_W-1:0] target;
  logic [CTRL_W-1:0] ctrl;

  assign op     = op_e'(uword[OP_LSB +: 3]);
  assign cond   = cond_e'(uword[COND_LSB +: 3]);
  assign target = uword[TGT_LSB +: ADDR_W];
  assign ctrl   = uword[CTRL_W-1:0];

  state_e            state_reg;
  logic [ADDR_W-1:0] car_reg, car_next, car_inc;
  logic [CTRL_W-1:0] ctrl_out_reg;
  logic              done_reg, err_reg;

  logic              cond_true, run_en, fault, is_end;
  logic              push, pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_dout;

  assign car_inc = car_reg + ADDR_W'(1);
  assign run_en  = (state_reg == ST_RUN) && !hold;

  // flags = {N,C,V,Z}
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_TRUE: cond_true = 1'b1;
      COND_Z:    cond_true = flags[0];
      COND_N:    cond_true = flags[3];
      COND_C:    cond_true = flags[2];
      COND_V:    cond_true = flags[1];
      COND_NZ:   cond_true = !flags[0];
      COND_NN:   cond_true = !flags[3];
      COND_NC:   cond_true = !flags[2];
      default:   cond_true = 1'b0;
    endcase
  end

  always_comb begin
    car_next = car_inc;
    push     = 1'b0;
    pop      = 1'b0;
    fault    = 1'b0;
    is_end   = 1'b0;
    case (op)
      OP_NEXT:     car_next = car_inc;
      OP_JUMP:     car_next = target;
      OP_BRC:      car_next = cond_true ? target : car_inc;
      OP_DISPATCH: car_next = map_addr;
      OP_CALL: begin
        car_next = target;
        fault    = stk_full;
        push     = run_en && !stk_full;
      end
      OP_RET: begin
        car_next = stk_dout;
        fault    = stk_empty;
        pop      = run_en && !stk_empty;
      end
      OP_WAIT:     car_next = mem_done ? car_inc : car_reg;
      OP_END: begin
        car_next = RESET_ADDR;
        is_end   = 1'b1;
      end
      default:     car_next = car_inc;
    endcase
  end

  micro_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_stack (
    .CLK    (CLK),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    (car_inc),
    .dout   (stk_dout),
    .full   (stk_full),
    .empty  (stk_empty)
  );

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_reg    <= ST_RUN;
      car_reg      <= RESET_ADDR;
      ctrl_out_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else if (state_reg == ST_HALT) begin
      ctrl_out_reg <= '0;
      done_reg     <= 1'b0;
    end else if (hold) begin
      done_reg <= 1'b0;
    end else if (fault) begin
      // CAR stays on the faulting word so it can be inspected after the halt
      state_reg    <= ST_HALT;
      ctrl_out_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b1;
    end else begin
      car_reg      <= car_next;
      ctrl_out_reg <= ctrl;
      done_reg     <= is_end;
    end
  end

  assign uaddr    = car_reg;
  assign ctrl_out = ctrl_out_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: doc/microsequencer_stack.md
Name: microsequencer_stack

Overview:
- Parametrised next-generation microprogram sequencer for the microcoded control unit. It owns the control address register (CAR) and the next-address logic, and registers the control buffer (CBR).
- Adds what the previous unit lacked: conditional branches on ALU flags, opcode dispatch, microsubroutine call/return on a hardware stack, a wait-for-memory stall and an error halt.
- Drives the address of an external control store, consumes the microword it returns, and emits the registered control-signal bus to the datapath.

Parameters:
- ADDR_W, 7, control-store address width.
- CTRL_W, 27, control-signal field width; bit CTRL_W-1 is unused by the sequencer and is passed through.
- STACK_DEPTH, 4, return-stack entries; must be 2..16.
- RESET_ADDR, 0, microaddress of the fetch routine.

Ports:
- CLK  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- uaddr  out  ADDR_W  current CAR value, sent to the control store.
- uword  in  CTRL_W+6+ADDR_W  microword for uaddr, combinational read, same cycle.
  - [CTRL_W-1:0] ctrl.
  - [CTRL_W+2:CTRL_W] op.
  - [CTRL_W+5:CTRL_W+3] cond.
  - [top ADDR_W bits] target.
- map_addr  in  ADDR_W  dispatch address from the instruction decoder.
- flags  in  4  {N,C,V,Z} from the ALU.
- mem_done  in  1  memory-function-complete.
- hold  in  1  external freeze.
- ctrl_out  out  CTRL_W  registered control bus (CBR).
- done  out  1  one-cycle pulse when an END microword executes.
- err  out  1  sticky stack fault.

Behaviour:
Reset (reset_n=0 at a rising edge):
- CAR=RESET_ADDR, ctrl_out=0, done=0, err=0, stack pointer sp=0, state=RUN.
- Reset overrides hold, a pending WAIT and HALT.

States:
- RUN: sequencing normally.
- HALT: entered on a stack fault. CAR and ctrl_out freeze, ctrl_out is forced to 0 and err=1. Only reset leaves HALT.
- A WAIT is not a separate state; it is the condition of not advancing, described under op codes.

Per advancing cycle (RUN, hold=0, not stalled):
- ctrl_out <= uword.ctrl.
- CAR <= next.
- One microinstruction is accepted per cycle.
- ctrl_out lags uaddr by one cycle.

hold=1:
- CAR, ctrl_out, sp and the stack are unchanged.
- done=0 in that cycle.

cond mux:
- 0 = true, 1 = Z, 2 = N, 3 = C, 4 = V.
- 5 = !Z, 6 = !N, 7 = !C.

op codes:
- 0 NEXT: next = CAR+1.
- 1 JUMP: next = target.
- 2 BRC: next = cond ? target : CAR+1.
- 3 DISPATCH: next = map_addr.
- 4 CALL: push CAR+1, then next = target.
- 5 RET: next = the popped value.
- 6 WAIT:
  - ctrl_out <= uword.ctrl on every cycle the word is held, so the memory strobes stay asserted.
  - When mem_done=0, CAR holds.
  - When mem_done=1, next = CAR+1.
  - mem_done arriving in the first cycle of the WAIT gives zero extra cycles.
- 7 END: next = RESET_ADDR; done=1 for that cycle only.

Address arithmetic:
- CAR+1 is modulo 2^ADDR_W, so address 127 wraps to 0 with no flag.

Stack faults:
- CALL with sp==STACK_DEPTH (overflow): no push, CAR unchanged, err=1, go to HALT.
- RET with sp==0 (underflow): same response as overflow.
- A CALL that fills the stack exactly (sp becomes STACK_DEPTH) is legal.

Other rules:
- Flags and map_addr are sampled in the same cycle as the microword that uses them.
- A stack push or pop takes effect at the same clock edge as the CAR update.

Decomposition:
- Shared package microseq_pkg holds:
  - op encodings OP_NEXT..OP_END;
  - cond encodings COND_TRUE..COND_NC;
  - microword field offset functions of CTRL_W and ADDR_W.
- One sub-module, micro_stack (LIFO, parameters STACK_DEPTH and ADDR_W):
  - inputs push, pop, din;
  - outputs dout, full, empty;
  - synchronous active-low reset clears sp.
- Next-address mux, cond mux and the state register stay in the top module.

Test Plan:
- Reset then NEXT run: reset_n=0 for 2 cycles, store holds NEXT at 0..3 with ctrl=0x1, 0x2, 0x4, 0x8.
  - uaddr runs 0, 1, 2, 3.
  - ctrl_out is 0x1 at the cycle where uaddr=1.
- Conditional branch: BRC cond=1 target=0x40 at address 5.
  - flags=4'b0001 -> uaddr=0x40 next cycle.
  - flags=4'b0000 -> uaddr=6.
  - cond=5 with Z=1 -> uaddr=6.
- Call nesting: 4 nested CALLs then 4 RETs (STACK_DEPTH=4).
  - Returns land at each call site+1 in reverse order; err=0.
  - A 5th CALL -> err=1, ctrl_out=0, uaddr frozen, and it stays so until reset_n=0.
- WAIT handshake: WAIT at 0x10 with ctrl=0x300, mem_done low for 3 cycles, then high.
  - uaddr stays 0x10 for 4 cycles, ctrl_out=0x300 throughout, then uaddr=0x11.
- Dispatch and END: DISPATCH with map_addr=0x22, then END at 0x22.
  - uaddr=0x22, then done pulses for exactly 1 cycle, then uaddr=RESET_ADDR.
  - hold=1 for 2 cycles mid-routine freezes uaddr, ctrl_out and sp.
  - Reset asserted during WAIT and during HALT returns uaddr=0, err=0.
